// File: rtl/p2s_pkg.sv
// Shared sizing helpers for the multi-bit parallel-to-serial converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package p2s_pkg;

  // Number of W-bit beats needed to carry one N-bit word.
  function automatic int p2s_beats(input int n, input int w);
    return n / w;
  endfunction

  // Beat counter width; kept at least 1 bit so BEATS = 1 still has a counter.
  function automatic int p2s_cw(input int n, input int w);
    int b;
    b = n / w;
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/p2s_shift.sv
// Shift register, beat counter and output lane select for one word in flight.
// Latency: a load at edge k presents the first beat after edge k.
// Backpressure: while ser_valid_o && !ser_ready_i, sreg/cnt and all outputs hold.
//
// Ports:
//   clk, rstn    - clock, async active-low reset
//   load_i       - capture load_dat_i, restart beat count (overrides shift)
//   load_dat_i   - word to serialise
//   ser_ready_i  - downstream accepts current beat
//   ser_data_o   - current W-bit beat
//   ser_valid_o  - a word is in flight
//   ser_last_o   - current beat is the final one of the word
//   fin_o        - final beat consumed this cycle
module p2s_shift
  import p2s_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [N-1:0] load_dat_i,
  input  logic         ser_ready_i,
  output logic [W-1:0] ser_data_o,
  output logic         ser_valid_o,
  output logic         ser_last_o,
  output logic         fin_o
);

  localparam int BEATS = p2s_beats(N, W);
  localparam int CW    = p2s_cw(N, W);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          svalid_q, svalid_d;
  logic          fire;
  logic          last;

  assign fire = svalid_q && ser_ready_i;
  assign last = svalid_q && (cnt_q == LAST_CNT);

  assign ser_valid_o = svalid_q;
  assign ser_last_o  = last;
  assign fin_o       = fire && last;

  // Output lane is always at the end the shifter drains toward.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign ser_data_o = sreg_q[N-1 -: W];
    end else begin : g_lsb
      assign ser_data_o = sreg_q[W-1:0];
    end
  endgenerate

  always_comb begin
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    svalid_d = svalid_q;
    if (load_i) begin
      sreg_d   = load_dat_i;
      cnt_d    = '0;
      svalid_d = 1'b1;
    end else if (fire && last) begin
      svalid_d = 1'b0;
    end else if (fire) begin
      // Zero-fill the vacated lane so stale bits never reach the output end.
      sreg_d = (MSB_FIRST != 0) ? (sreg_q << W) : (sreg_q >> W);
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      svalid_q <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      svalid_q <= svalid_d;
    end
  end

endmodule

// File: rtl/p2s_multi.sv
// Parallel-to-serial converter: N-bit words in, N/W beats of W bits out, last beat flagged.
// Latency: par_fire at edge k with the shifter idle gives the first beat after edge k.
// Backpressure: one-word holding stage; par_ready = !hvalid, serial side holds while !ser_ready.
//
// Ports:
//   clk, rstn  - clock, async active-low reset
//   par_data   - parallel word in;  par_valid / par_ready handshake
//   ser_data   - W-bit beat out;    ser_valid / ser_ready handshake
//   ser_last   - current beat is the final beat of its word
module p2s_multi
  import p2s_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic [W-1:0] ser_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last
);

  generate
    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
      $error("p2s_multi: N must be a positive multiple of W");
    end
  endgenerate

  logic [N-1:0] hreg_q, hreg_d;
  logic         hvalid_q, hvalid_d;
  logic         par_fire;
  logic         load;
  logic [N-1:0] load_dat;
  logic         svalid;
  logic         fin;

  assign par_ready = !hvalid_q;
  assign par_fire  = par_valid && !hvalid_q;
  assign ser_valid = svalid;

  // Shifter refills when empty or finishing its last beat this cycle, which is
  // what lets consecutive words stream without a bubble.
  assign load     = (!svalid || fin) && (hvalid_q || par_fire);
  assign load_dat = hvalid_q ? hreg_q : par_data;

  always_comb begin
    hreg_d   = hreg_q;
    hvalid_d = hvalid_q;
    if (par_fire && (!load || hvalid_q)) begin
      // Incoming word cannot bypass straight into the shifter: park it.
      hreg_d   = par_data;
      hvalid_d = 1'b1;
    end else if (load && hvalid_q) begin
      hvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hreg_q   <= '0;
      hvalid_q <= 1'b0;
    end else begin
      hreg_q   <= hreg_d;
      hvalid_q <= hvalid_d;
    end
  end

  p2s_shift #(
    .N        (N),
    .W        (W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (load),
    .load_dat_i (load_dat),
    .ser_ready_i(ser_ready),
    .ser_data_o (ser_data),
    .ser_valid_o(svalid),
    .ser_last_o (ser_last),
    .fin_o      (fin)
  );

endmodule

// File: tb/tb_p2s_multi.sv
// Directed bench for p2s_multi in three configurations: W=1 MSB-first, W=2 LSB-first, W=N=8.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
// Ends with a single passed/total summary line.
module tb_p2s_multi;

  logic clk;
  logic rstn;

  // u0: N=8, W=1, MSB first
  logic [7:0] a_par_data;
  logic       a_par_valid, a_par_ready;
  logic [0:0] a_ser_data;
  logic       a_ser_valid, a_ser_ready, a_ser_last;
  // u1: N=8, W=2, LSB first
  logic [7:0] b_par_data;
  logic       b_par_valid, b_par_ready;
  logic [1:0] b_ser_data;
  logic       b_ser_valid, b_ser_ready, b_ser_last;
  // u2: N=8, W=8
  logic [7:0] c_par_data;
  logic       c_par_valid, c_par_ready;
  logic [7:0] c_ser_data;
  logic       c_ser_valid, c_ser_ready, c_ser_last;

  int n_total;
  int n_pass;

  p2s_multi #(.N(8), .W(1), .MSB_FIRST(1)) u0 (
    .clk(clk), .rstn(rstn),
    .par_data(a_par_data), .par_valid(a_par_valid), .par_ready(a_par_ready),
    .ser_data(a_ser_data), .ser_valid(a_ser_valid), .ser_ready(a_ser_ready),
    .ser_last(a_ser_last)
  );

  p2s_multi #(.N(8), .W(2), .MSB_FIRST(0)) u1 (
    .clk(clk), .rstn(rstn),
    .par_data(b_par_data), .par_valid(b_par_valid), .par_ready(b_par_ready),
    .ser_data(b_ser_data), .ser_valid(b_ser_valid), .ser_ready(b_ser_ready),
    .ser_last(b_ser_last)
  );

  p2s_multi #(.N(8), .W(8), .MSB_FIRST(1)) u2 (
    .clk(clk), .rstn(rstn),
    .par_data(c_par_data), .par_valid(c_par_valid), .par_ready(c_par_ready),
    .ser_data(c_ser_data), .ser_valid(c_ser_valid), .ser_ready(c_ser_ready),
    .ser_last(c_ser_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] bits;
    logic [15:0] stream;
    logic [7:0] lanes;
    logic [7:0] words [3];

    n_total = 0;
    n_pass  = 0;
    rstn = 1'b0;
    a_par_data = '0; a_par_valid = 1'b0; a_ser_ready = 1'b0;
    b_par_data = '0; b_par_valid = 1'b0; b_ser_ready = 1'b0;
    c_par_data = '0; c_par_valid = 1'b0; c_ser_ready = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst ser_valid", a_ser_valid, 0);
    chk("rst ser_last",  a_ser_last,  0);
    chk("rst ser_data",  a_ser_data,  0);
    chk("rst par_ready", a_par_ready, 1);
    rstn = 1'b1;
    @(negedge clk);

    // ---- single word 0x3E, W=1, MSB first ----
    bits = 8'b0011_1110;
    a_par_data = 8'h3E; a_par_valid = 1'b1; a_ser_ready = 1'b1;
    @(negedge clk);
    a_par_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1 valid%0d", i), a_ser_valid, 1);
      chk($sformatf("t1 data%0d", i),  a_ser_data,  bits[7-i]);
      chk($sformatf("t1 last%0d", i),  a_ser_last,  (i == 7) ? 1 : 0);
      @(negedge clk);
    end
    chk("t1 idle", a_ser_valid, 0);

    // ---- back-to-back 0xA5, 0x3C ----
    stream = 16'b1010_0101_0011_1100;
    a_par_data = 8'hA5; a_par_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) a_par_data = 8'h3C;
      if (i == 1) a_par_valid = 1'b0;
      chk($sformatf("t2 valid%0d", i), a_ser_valid, 1);
      chk($sformatf("t2 data%0d", i),  a_ser_data,  stream[15-i]);
      chk($sformatf("t2 last%0d", i),  a_ser_last,  (i == 7 || i == 15) ? 1 : 0);
      chk($sformatf("t2 pready%0d", i), a_par_ready, (i >= 1 && i <= 7) ? 0 : 1);
      @(negedge clk);
    end
    chk("t2 idle", a_ser_valid, 0);

    // ---- backpressure on 8'd52 ----
    bits = 8'b0011_0100;
    a_par_data = 8'd52; a_par_valid = 1'b1;
    @(negedge clk);
    a_par_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t3 data%0d", i), a_ser_data, bits[7-i]);
      @(negedge clk);
    end
    a_ser_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("t3 stall valid%0d", s), a_ser_valid, 1);
      chk($sformatf("t3 stall data%0d", s),  a_ser_data,  bits[5]);
      chk($sformatf("t3 stall last%0d", s),  a_ser_last,  0);
      chk($sformatf("t3 stall cnt%0d", s),   u0.u_shift.cnt_q, 2);
    end
    a_ser_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      chk($sformatf("t3 valid%0d", i), a_ser_valid, 1);
      chk($sformatf("t3 data%0d", i),  a_ser_data,  bits[7-i]);
      chk($sformatf("t3 last%0d", i),  a_ser_last,  (i == 7) ? 1 : 0);
      @(negedge clk);
    end
    chk("t3 idle", a_ser_valid, 0);

    // ---- W=2, LSB first, 0xB4 -> 00,01,11,10 ----
    lanes = 8'b00_01_11_10;
    b_par_data = 8'hB4; b_par_valid = 1'b1; b_ser_ready = 1'b1;
    @(negedge clk);
    b_par_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4 valid%0d", i), b_ser_valid, 1);
      chk($sformatf("t4 data%0d", i),  b_ser_data,  lanes[7-2*i -: 2]);
      chk($sformatf("t4 last%0d", i),  b_ser_last,  (i == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("t4 idle", b_ser_valid, 0);

    // ---- W=N=8, 0x11, 0x22, 0x33 at full rate ----
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    c_par_data = 8'h11; c_par_valid = 1'b1; c_ser_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5 valid%0d", i),  c_ser_valid, 1);
      chk($sformatf("t5 data%0d", i),   c_ser_data,  words[i]);
      chk($sformatf("t5 last%0d", i),   c_ser_last,  1);
      chk($sformatf("t5 pready%0d", i), c_par_ready, 1);
      if (i < 2) c_par_data = words[i+1];
      else       c_par_valid = 1'b0;
      @(negedge clk);
    end
    chk("t5 idle", c_ser_valid, 0);

    // ---- async reset mid-word, with 0x81 held ----
    a_par_data = 8'hFF; a_par_valid = 1'b1;
    @(negedge clk);
    a_par_data = 8'h81;
    @(negedge clk);
    a_par_valid = 1'b0;
    chk("t6 held pready", a_par_ready, 0);
    @(negedge clk);
    chk("t6 beat3 data", a_ser_data, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6 rst ser_valid", a_ser_valid, 0);
    chk("t6 rst par_ready", a_par_ready, 1);
    chk("t6 rst ser_last",  a_ser_last,  0);
    chk("t6 rst ser_data",  a_ser_data,  0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bits = 8'b0000_1111;
    a_par_data = 8'h0F; a_par_valid = 1'b1;
    @(negedge clk);
    a_par_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6 valid%0d", i), a_ser_valid, 1);
      chk($sformatf("t6 data%0d", i),  a_ser_data,  bits[7-i]);
      chk($sformatf("t6 last%0d", i),  a_ser_last,  (i == 7) ? 1 : 0);
      @(negedge clk);
    end
    chk("t6 idle", a_ser_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
